// File: rtl/rtc_bcd_timekeeper.sv
// rtc_bcd_timekeeper: BCD real-time clock/calendar with prescaler, halt control and a single time-of-day alarm.
module rtc_bcd_timekeeper #(
  parameter int C_CLK_HZ   = 25000000,
  parameter int C_TICK_DIV = C_CLK_HZ,
  parameter int C_ALARM    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [7:0]  data,
  input  logic        alarm_set,
  input  logic [23:0] alarm_time,
  input  logic        alarm_en,
  input  logic        alarm_ack,
  output logic        tick,
  output logic [55:0] datetime_o,
  output logic        halted,
  output logic        alarm_pulse,
  output logic        alarm_flag
);
  localparam int CW = C_TICK_DIV > 1 ? $clog2(C_TICK_DIV) : 1;
  localparam logic [55:0] DT_RST = 56'h00_01_01_01_00_00_00;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [55:0]   dt_q, dt_d, adv;
  logic [23:0]   al_time_q;
  logic          al_en_q, halted_q, halted_d, tick_q, adv_q, pulse_q, pulse_d, flag_q, flag_d;
  logic          tc, leap, c_ss, c_mi, c_hh, c_dd, c_mo;
  logic [7:0]    ss, mi, hh, wd, dd, mo, yy, dim;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx, input logic [7:0] mn);
    return v >= mx ? mn : (v[3:0] >= 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1);
  endfunction
  assign {yy, mo, dd, wd, hh, mi, ss} = dt_q;
  assign tc = !halted_q && cnt_q == CW'(C_TICK_DIV - 1);
  // YY divisible by 4 in BCD: (2*tens + units) mod 4 == 0
  assign leap = (yy[1:0] + {yy[4], 1'b0}) == 2'd0;
  assign dim = mo == 8'h02 ? (leap ? 8'h29 : 8'h28) :
               (mo == 8'h04 || mo == 8'h06 || mo == 8'h09 || mo == 8'h11) ? 8'h30 : 8'h31;
  assign c_ss = ss >= 8'h59;
  assign c_mi = c_ss && mi >= 8'h59;
  assign c_hh = c_mi && hh >= 8'h23;
  assign c_dd = c_hh && dd >= dim;
  assign c_mo = c_dd && mo >= 8'h12;
  assign adv = {c_mo ? bcd_inc(yy, 8'h99, 8'h00) : yy,
                c_dd ? bcd_inc(mo, 8'h12, 8'h01) : mo,
                c_hh ? bcd_inc(dd, dim, 8'h01) : dd,
                c_hh ? bcd_inc(wd, 8'h07, 8'h01) : wd,
                c_mi ? bcd_inc(hh, 8'h23, 8'h00) : hh,
                c_ss ? bcd_inc(mi, 8'h59, 8'h00) : mi,
                bcd_inc(ss, 8'h59, 8'h00)};
  always_comb begin
    dt_d = wr ? dt_q : (tc ? adv : dt_q);
    if (wr && addr != 3'd7) dt_d[{addr, 3'b000} +: 8] = data;
    cnt_d = (wr && addr == 3'd0) ? '0 : halted_q ? cnt_q : tc ? '0 : cnt_q + CW'(1);
    halted_d = (wr && addr == 3'd7) ? data[0] : halted_q;
    // match is judged one cycle after a real advance, so writes can never trigger it
    pulse_d = C_ALARM != 0 && adv_q && al_en_q && dt_q[23:0] == al_time_q;
    flag_d = pulse_d || (flag_q && !alarm_ack);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      dt_q      <= DT_RST;
      al_time_q <= '0;
      al_en_q   <= 1'b0;
      halted_q  <= 1'b0;
      tick_q    <= 1'b0;
      adv_q     <= 1'b0;
      pulse_q   <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dt_q      <= dt_d;
      al_time_q <= alarm_set ? alarm_time : al_time_q;
      al_en_q   <= alarm_set ? alarm_en : al_en_q;
      halted_q  <= halted_d;
      tick_q    <= tc;
      adv_q     <= tc && !wr;
      pulse_q   <= pulse_d;
      flag_q    <= flag_d;
    end
  end
  assign tick        = tick_q;
  assign datetime_o  = dt_q;
  assign halted      = halted_q;
  assign alarm_pulse = pulse_q;
  assign alarm_flag  = flag_q;
endmodule

// File: tb/tb_rtc_bcd_timekeeper.sv
// tb_rtc_bcd_timekeeper: directed bench for rtc_bcd_timekeeper with a 4-cycle second.
module tb_rtc_bcd_timekeeper;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  addr = '0;
  logic [7:0]  data = '0;
  logic        alarm_set = 1'b0;
  logic [23:0] alarm_time = '0;
  logic        alarm_en = 1'b0;
  logic        alarm_ack = 1'b0;
  logic        tick, halted, alarm_pulse, alarm_flag;
  logic [55:0] datetime_o;
  int total = 0;
  int bad = 0;
  int seen;

  rtc_bcd_timekeeper #(.C_CLK_HZ(100), .C_TICK_DIV(4), .C_ALARM(1)) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .addr(addr), .data(data),
    .alarm_set(alarm_set), .alarm_time(alarm_time), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .tick(tick), .datetime_o(datetime_o), .halted(halted),
    .alarm_pulse(alarm_pulse), .alarm_flag(alarm_flag));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [55:0] obs, input logic [55:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_field(input logic [2:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; data = d;
    step();
    wr = 1'b0;
  endtask

  task automatic run_ticks(input int n, input string tag);
    seen = 0;
    for (int i = 0; i < 4 * n + 8 && seen < n; i++) begin
      step();
      if (tick) seen++;
    end
    chk(tag, 56'(seen), 56'(n));
  endtask

  task automatic set_time(input logic [7:0] yy, mo, dd, hh, mi, ss);
    wr_field(3'd7, 8'h01);
    wr_field(3'd6, yy);
    wr_field(3'd5, mo);
    wr_field(3'd4, dd);
    wr_field(3'd2, hh);
    wr_field(3'd1, mi);
    wr_field(3'd0, ss);
    wr_field(3'd7, 8'h00);
  endtask

  initial begin
    step();
    step();
    chk("rst_dt", datetime_o, 56'h00_01_01_01_00_00_00);
    chk("rst_outs", {52'd0, tick, halted, alarm_pulse, alarm_flag}, 56'd0);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("idle_tick", 56'(tick), 56'(i % 4 == 3));
      if (tick) seen++;
    end
    chk("idle_count", 56'(seen), 56'd3);
    chk("idle_ss", datetime_o, 56'h00_01_01_01_00_00_03);

    set_time(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h58);
    chk("halt_clear", 56'(halted), 56'd0);
    run_ticks(2, "yr_ticks");
    chk("year_wrap", datetime_o, 56'h00_01_01_02_00_00_00);

    set_time(8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    run_ticks(1, "leap_ticks");
    chk("leap_feb29", datetime_o, 56'h24_02_29_03_00_00_00);
    set_time(8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
    run_ticks(1, "nonleap_ticks");
    chk("nonleap_mar1", datetime_o, 56'h23_03_01_04_00_00_00);

    step(); step(); step();
    wr = 1'b1; addr = 3'd1; data = 8'h30;
    step();
    wr = 1'b0;
    chk("coll_tick", 56'(tick), 56'd1);
    chk("coll_dt", datetime_o, 56'h23_03_01_04_00_30_00);
    run_ticks(1, "post_coll_ticks");
    chk("post_coll_dt", datetime_o, 56'h23_03_01_04_00_30_01);

    alarm_set = 1'b1; alarm_time = 24'h00_00_02; alarm_en = 1'b1;
    step();
    alarm_set = 1'b0; alarm_en = 1'b0; alarm_time = '0;
    set_time(8'h23, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00);
    run_ticks(1, "al_tick1");
    chk("al_no_early", 56'(alarm_pulse), 56'd0);
    run_ticks(1, "al_tick2");
    chk("al_dt", datetime_o, 56'h23_03_01_04_00_00_02);
    chk("al_tick_cycle", {54'd0, alarm_pulse, alarm_flag}, 56'd0);
    step();
    chk("al_pulse", {54'd0, alarm_pulse, alarm_flag}, 56'd3);
    step();
    chk("al_pulse_end", {54'd0, alarm_pulse, alarm_flag}, 56'd1);

    wr_field(3'd7, 8'h01);
    chk("halted", 56'(halted), 56'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tick) seen++;
    end
    chk("halt_no_ticks", 56'(seen), 56'd0);
    chk("halt_dt", datetime_o, 56'h23_03_01_04_00_00_02);
    chk("flag_held", 56'(alarm_flag), 56'd1);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    chk("ack_clear", 56'(alarm_flag), 56'd0);

    wr_field(3'd0, 8'h01);
    wr_field(3'd0, 8'h02);
    chk("halt_write", datetime_o, 56'h23_03_01_04_00_00_02);
    step(); step();
    chk("write_no_alarm", {54'd0, alarm_pulse, alarm_flag}, 56'd0);

    wr_field(3'd7, 8'h00);
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_dt", datetime_o, 56'h00_01_01_01_00_00_00);
    chk("async_rst_outs", {52'd0, tick, halted, alarm_pulse, alarm_flag}, 56'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (tick) seen++;
    end
    chk("restart_period", {55'(seen), tick}, {55'd1, 1'b1});
    chk("restart_dt", datetime_o, 56'h00_01_01_01_00_00_01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
